pin_entry: RTL and testbench
============================

# pin_entry

Digit-by-digit PIN collector that drives the `userPin`/`validPin` side of the PIN-verification handshake. It accepts one BCD digit per debounced press from the switch bank and assembles four digits into a 16-bit PIN. It then issues a one-cycle submit pulse and waits for the verifier's `success_event`/`fail_event` response. It also enforces an entry inactivity timeout and an optional lockout after repeated failures, and it sits between the board buttons/switches and the verifier in the top level.

## Interface
Parameters:
- `DEBOUNCE`, 4: consecutive equal samples needed to change a clean button level.
- `ENTRY_TIMEOUT`, 2500: idle cycles allowed between digits while in ENTRY (5 s at 500 Hz).
- `RESP_TIMEOUT`, 8: cycles to wait for a verifier response after submit.
- `MAX_FAILS`, 3: consecutive failures that trigger lockout.
- `LOCKOUT_CYCLES`, 5000: lockout duration (10 s).

Ports:
- `clk_500Hz` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `digit_sw` in 4: BCD digit to enter.
- `btnC` in 1: raw "enter digit" button.
- `btnU` in 1: raw "clear entry" button.
- `success_event` in 1: one-cycle pulse from the verifier on a PIN match.
- `fail_event` in 1: one-cycle pulse from the verifier on a PIN mismatch.
- `userPin` out 16: assembled PIN; first digit in [15:12], last digit in [3:0].
- `validPin` out 1: one-cycle submit pulse.
- `digit_count` out 3: digits entered so far, 0–4.
- `entry_active` out 1: high while in ENTRY.
- `locked` out 1: high while in LOCKED.

## Operation
- Debounce: each button feeds a `DEBOUNCE`-bit shift register. The clean level goes to 1 when all bits are 1 and to 0 when all bits are 0. A press is a 0→1 transition of the clean level.
- States: IDLE, ENTRY, SUBMIT, WAIT_RESULT, LOCKED.
- Digit accept (IDLE or ENTRY, `btnC` press, `digit_sw` ≤ 9):
  - `userPin <= {userPin[11:0], digit_sw}` and `digit_count` increments.
  - The inactivity timer clears and the state becomes ENTRY.
  - A `digit_sw` value of 10–15 is ignored: no shift, no count change, timer not cleared.
- Fourth digit accepted → SUBMIT.
- SUBMIT lasts exactly one cycle with `validPin`=1, then goes to WAIT_RESULT with the response timer cleared.
- WAIT_RESULT:
  - `success_event` → fail counter cleared; `userPin` and `digit_count` cleared; → IDLE.
  - `fail_event` → fail counter increments. If it reaches `MAX_FAILS`, go to LOCKED and clear the fail counter; otherwise go to IDLE. Either way, `userPin` and `digit_count` are cleared.
  - No event within `RESP_TIMEOUT` cycles (the verifier is not armed) → IDLE with digits cleared and the fail counter unchanged.
- ENTRY:
  - A `btnU` press clears `userPin` and `digit_count` → IDLE.
  - The inactivity timer reaching `ENTRY_TIMEOUT`-1 has the same effect.
- LOCKED: counts `LOCKOUT_CYCLES` cycles, then → IDLE. All button presses and events are ignored while locked.
- Boundary rules:
  - `btnC` and `btnU` presses in the same cycle: clear wins.
  - `success_event` and `fail_event` in the same cycle: success wins.
  - An event in the same cycle as the response timeout: the event wins.
  - Events outside WAIT_RESULT are ignored and not counted.
  - Button presses in SUBMIT or WAIT_RESULT are discarded. The debouncers still track the button, so a button still held on return to IDLE does not register as a new press.
- Fail-counter width: `$clog2(MAX_FAILS+1)`. Timer widths are sized to their parameters with no wrap inside a state.

## Timing
- Reset values: `userPin`=0, `validPin`=0, `digit_count`=0, `entry_active`=0, `locked`=0; state IDLE; all counters 0; debouncers at 0.
- `rst` asserted in any state returns to IDLE on the next edge. A pending submit is cancelled, and `validPin` is never emitted for a partial entry.
- Latency from a raw button held high to the digit being shifted in is `DEBOUNCE`+1 cycles.
- `validPin` rises the cycle after the fourth digit is accepted.
- `userPin` is held stable from SUBMIT until the exit from WAIT_RESULT.
- The verifier's events arrive 1 cycle after it samples `validPin`, which is well within `RESP_TIMEOUT`.
- All outputs are registered.

## Configuration
- `PIN_ENTRY_LOCKOUT_EN` defined: fail counter, LOCKED state and lockout timer are present, as described above.
- Not defined:
  - The fail counter, LOCKED state and lockout timer are removed, and `locked` is tied to 0.
  - `fail_event` → IDLE with digits cleared. Fail attempts are unlimited.

## Test plan
- Reset, then enter digits 1, 2, 3, 4 → `validPin` pulses high for exactly one cycle with `userPin`=16'h1234. Drive `success_event` 1 cycle later → IDLE, `userPin`=0.
- Enter 5, then set `digit_sw`=4'hB and press, then enter 6 → `digit_count`=2, `userPin`[7:0]=8'h56.
- Enter 7, 8, then stop for 2500 cycles → `digit_count`=0, `entry_active`=0. Also press `btnC` and `btnU` together mid-entry → the entry is cleared.
- With `PIN_ENTRY_LOCKOUT_EN`, three submits each answered by `fail_event` → `locked`=1. Presses during lockout are ignored, and `locked`=0 after 5000 cycles.
- Submit with no response → IDLE after 8 cycles with the fail count unchanged. A later `fail_event`-only sequence still needs 3 failures to lock.
- Assert `rst` during SUBMIT → `validPin` stays 0 and all outputs return to their reset values.

Source files
------------

// File: rtl/pin_entry.sv
// pin_entry - digit-by-digit PIN collector feeding the PIN verifier.
//
// It debounces the enter and clear buttons. It shifts one BCD digit into
// userPin for each accepted enter press. After the fourth digit it raises
// validPin for one cycle, then waits for the verifier to answer with
// success_event or fail_event. It also enforces an inactivity timeout
// while digits are being entered.
//
// Optional feature macro: PIN_ENTRY_LOCKOUT_EN
//   defined   : consecutive failures are counted. MAX_FAILS failures in a row
//               lock the entry for LOCKOUT_CYCLES cycles.
//   undefined : failures are unlimited and locked is tied low.
//
// Ports:
//   clk_500Hz      in   sole clock
//   rst            in   synchronous active-high reset
//   digit_sw[3:0]  in   BCD digit to enter (10..15 are ignored)
//   btnC           in   raw "enter digit" button
//   btnU           in   raw "clear entry" button
//   success_event  in   verifier pulse: PIN matched
//   fail_event     in   verifier pulse: PIN mismatched
//   userPin[15:0]  out  assembled PIN, first digit in [15:12]
//   validPin       out  one-cycle submit pulse
//   digit_count    out  digits entered so far (0..4)
//   entry_active   out  high while digits are being entered
//   locked         out  high during lockout
module pin_entry #(
    parameter int DEBOUNCE       = 4,
    parameter int ENTRY_TIMEOUT  = 2500,
    parameter int RESP_TIMEOUT   = 8,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 5000
) (
    input  logic        clk_500Hz,
    input  logic        rst,
    input  logic [3:0]  digit_sw,
    input  logic        btnC,
    input  logic        btnU,
    input  logic        success_event,
    input  logic        fail_event,
    output logic [15:0] userPin,
    output logic        validPin,
    output logic [2:0]  digit_count,
    output logic        entry_active,
    output logic        locked
);

    localparam int ETW = $clog2(ENTRY_TIMEOUT + 1);
    localparam int RTW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [ETW-1:0] ENTRY_LAST = ETW'(ENTRY_TIMEOUT - 1);
    localparam logic [RTW-1:0] RESP_LAST  = RTW'(RESP_TIMEOUT - 1);
`ifdef PIN_ENTRY_LOCKOUT_EN
    localparam int LTW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int FW  = $clog2(MAX_FAILS + 1);
    localparam logic [LTW-1:0] LOCK_LAST = LTW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0]  FAIL_LAST = FW'(MAX_FAILS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_SUBMIT,
        S_WAIT_RESULT
`ifdef PIN_ENTRY_LOCKOUT_EN
        , S_LOCKED
`endif
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Button debouncers
    // ------------------------------------------------------------------
    logic [DEBOUNCE-1:0] btnC_sh, btnU_sh, btnC_sh_nx, btnU_sh_nx;
    logic                btnC_clean, btnU_clean, btnC_clean_q, btnU_clean_q;
    logic                press_c, press_u, digit_ok;

    always_comb begin
        btnC_sh_nx = (btnC_sh << 1) | DEBOUNCE'(btnC);
        btnU_sh_nx = (btnU_sh << 1) | DEBOUNCE'(btnU);
    end

    // The clean level is decided on the incoming sample window. A press
    // therefore reaches the FSM DEBOUNCE+1 edges after the button goes high.
    always_ff @(posedge clk_500Hz) begin
        if (rst) begin
            btnC_sh      <= '0;
            btnU_sh      <= '0;
            btnC_clean   <= 1'b0;
            btnU_clean   <= 1'b0;
            btnC_clean_q <= 1'b0;
            btnU_clean_q <= 1'b0;
        end else begin
            btnC_sh      <= btnC_sh_nx;
            btnU_sh      <= btnU_sh_nx;
            if (btnC_sh_nx == '1)      btnC_clean <= 1'b1;
            else if (btnC_sh_nx == '0) btnC_clean <= 1'b0;
            if (btnU_sh_nx == '1)      btnU_clean <= 1'b1;
            else if (btnU_sh_nx == '0) btnU_clean <= 1'b0;
            btnC_clean_q <= btnC_clean;
            btnU_clean_q <= btnU_clean;
        end
    end

    // The debouncers run in every state. A button held through
    // SUBMIT/WAIT_RESULT therefore shows no new edge on return to IDLE.
    assign press_c  = btnC_clean & ~btnC_clean_q;
    assign press_u  = btnU_clean & ~btnU_clean_q;
    assign digit_ok = (digit_sw <= 4'd9);

    // ------------------------------------------------------------------
    // Entry / submit FSM
    // ------------------------------------------------------------------
    logic [ETW-1:0] entry_timer;
    logic [RTW-1:0] resp_timer;
`ifdef PIN_ENTRY_LOCKOUT_EN
    logic [LTW-1:0] lock_timer;
    logic [FW-1:0]  fail_cnt;
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge clk_500Hz) begin
        if (rst) begin
            state        <= S_IDLE;
            userPin      <= '0;
            validPin     <= 1'b0;
            digit_count  <= '0;
            entry_active <= 1'b0;
            entry_timer  <= '0;
            resp_timer   <= '0;
`ifdef PIN_ENTRY_LOCKOUT_EN
            locked       <= 1'b0;
            lock_timer   <= '0;
            fail_cnt     <= '0;
`endif
        end else begin
            validPin <= 1'b0;
            case (state)
                S_IDLE, S_ENTRY: begin
                    if (press_u) begin
                        // Clear takes priority over a simultaneous enter.
                        userPin      <= '0;
                        digit_count  <= '0;
                        entry_timer  <= '0;
                        entry_active <= 1'b0;
                        state        <= S_IDLE;
                    end else if (press_c && digit_ok) begin
                        userPin     <= {userPin[11:0], digit_sw};
                        digit_count <= digit_count + 3'd1;
                        entry_timer <= '0;
                        if (digit_count == 3'd3) begin
                            entry_active <= 1'b0;
                            state        <= S_SUBMIT;
                        end else begin
                            entry_active <= 1'b1;
                            state        <= S_ENTRY;
                        end
                    end else if (state == S_ENTRY) begin
                        if (entry_timer == ENTRY_LAST) begin
                            userPin      <= '0;
                            digit_count  <= '0;
                            entry_timer  <= '0;
                            entry_active <= 1'b0;
                            state        <= S_IDLE;
                        end else begin
                            entry_timer <= entry_timer + 1'b1;
                        end
                    end
                end

                // validPin rises on leaving SUBMIT. A reset during SUBMIT
                // therefore cancels the submit before any pulse appears.
                S_SUBMIT: begin
                    validPin   <= 1'b1;
                    resp_timer <= '0;
                    state      <= S_WAIT_RESULT;
                end

                S_WAIT_RESULT: begin
                    if (success_event) begin
`ifdef PIN_ENTRY_LOCKOUT_EN
                        fail_cnt <= '0;
`endif
                        userPin     <= '0;
                        digit_count <= '0;
                        state       <= S_IDLE;
                    end else if (fail_event) begin
`ifdef PIN_ENTRY_LOCKOUT_EN
                        if (fail_cnt == FAIL_LAST) begin
                            fail_cnt   <= '0;
                            lock_timer <= '0;
                            locked     <= 1'b1;
                            state      <= S_LOCKED;
                        end else begin
                            fail_cnt <= fail_cnt + 1'b1;
                            state    <= S_IDLE;
                        end
`else
                        state <= S_IDLE;
`endif
                        userPin     <= '0;
                        digit_count <= '0;
                    end else if (resp_timer == RESP_LAST) begin
                        userPin     <= '0;
                        digit_count <= '0;
                        state       <= S_IDLE;
                    end else begin
                        resp_timer <= resp_timer + 1'b1;
                    end
                end

`ifdef PIN_ENTRY_LOCKOUT_EN
                S_LOCKED: begin
                    if (lock_timer == LOCK_LAST) begin
                        locked <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        lock_timer <= lock_timer + 1'b1;
                    end
                end
`endif

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pin_entry.sv
// Self-checking bench for pin_entry. Submitted PINs are pushed to a
// scoreboard queue and compared against userPin when validPin appears.
module tb_pin_entry;

    localparam int DB = 4;
    localparam int ET = 2500;
    localparam int RT = 8;
    localparam int MF = 3;
    localparam int LC = 5000;

    logic        clk_500Hz = 1'b0;
    logic        rst, btnC, btnU, success_event, fail_event;
    logic [3:0]  digit_sw;
    logic [15:0] userPin;
    logic        validPin, entry_active, locked;
    logic [2:0]  digit_count;

    pin_entry #(
        .DEBOUNCE      (DB),
        .ENTRY_TIMEOUT (ET),
        .RESP_TIMEOUT  (RT),
        .MAX_FAILS     (MF),
        .LOCKOUT_CYCLES(LC)
    ) dut (
        .clk_500Hz    (clk_500Hz),
        .rst          (rst),
        .digit_sw     (digit_sw),
        .btnC         (btnC),
        .btnU         (btnU),
        .success_event(success_event),
        .fail_event   (fail_event),
        .userPin      (userPin),
        .validPin     (validPin),
        .digit_count  (digit_count),
        .entry_active (entry_active),
        .locked       (locked)
    );

    always #5 clk_500Hz = ~clk_500Hz;

    int          n_checks = 0;
    int          n_err = 0;
    int          vp_count = 0;
    int          sb_pushed = 0;
    int          lock_cycles = 0;
    logic        vp_prev = 1'b0;
    logic [15:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every submit pulse must match the oldest queued PIN.
    always @(negedge clk_500Hz) begin
        if (validPin) begin
            vp_count <= vp_count + 1;
            check("vp_width", {31'b0, vp_prev}, 0);
            check("vp_expected", sb_q.size(), 1);
            if (sb_q.size() > 0) check("submit_pin", userPin, sb_q.pop_front());
        end
        vp_prev <= validPin;
        if (locked) lock_cycles <= lock_cycles + 1;
    end

    // All stimulus tasks start and end just after a rising edge.
    task automatic press(input logic [3:0] d);
        digit_sw = d;
        btnC = 1'b1;
        repeat (DB + 2) @(posedge clk_500Hz);
        #1 btnC = 1'b0;
        repeat (DB + 2) @(posedge clk_500Hz);
        #1;
    endtask

    task automatic press_clear(input bit with_enter);
        digit_sw = 4'd7;
        btnC = with_enter;
        btnU = 1'b1;
        repeat (DB + 2) @(posedge clk_500Hz);
        #1 btnC = 1'b0;
        btnU = 1'b0;
        repeat (DB + 2) @(posedge clk_500Hz);
        #1;
    endtask

    task automatic pulse_events(input bit s, input bit f);
        success_event = s;
        fail_event = f;
        @(posedge clk_500Hz);
        #1 success_event = 1'b0;
        fail_event = 1'b0;
    endtask

    // resp: 0 = no answer, 1 = success, 2 = fail, 3 = success and fail together
    task automatic submit(input logic [15:0] pin, input int resp);
        bit seen;
        press(pin[15:12]);
        press(pin[11:8]);
        press(pin[7:4]);
        sb_q.push_back(pin);
        sb_pushed++;
        digit_sw = pin[3:0];
        btnC = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_500Hz);
            if (validPin) begin
                seen = 1'b1;
                break;
            end
        end
        check("vp_seen", {31'b0, seen}, 1);
        if (resp == 0) begin
            repeat (RT - 1) @(posedge clk_500Hz);
            @(negedge clk_500Hz);
            check("rto_hold_cnt", digit_count, 4);
            check("rto_hold_pin", userPin, pin);
            @(posedge clk_500Hz);
            @(negedge clk_500Hz);
            check("rto_exit_cnt", digit_count, 0);
            check("rto_exit_pin", userPin, 0);
            @(posedge clk_500Hz);
            #1;
        end else begin
            @(posedge clk_500Hz);
            #1 success_event = (resp == 1 || resp == 3);
            fail_event = (resp == 2 || resp == 3);
            @(negedge clk_500Hz);
            check("hold_pin", userPin, pin);
            @(posedge clk_500Hz);
            #1 success_event = 1'b0;
            fail_event = 1'b0;
            @(negedge clk_500Hz);
            check("resp_clear_cnt", digit_count, 0);
            check("resp_clear_pin", userPin, 0);
            @(posedge clk_500Hz);
            #1;
        end
        btnC = 1'b0;
        repeat (DB + 2) @(posedge clk_500Hz);
        #1;
        check("held_no_press", digit_count, 0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        btnC = 1'b0;
        btnU = 1'b0;
        digit_sw = 4'd0;
        success_event = 1'b0;
        fail_event = 1'b0;
        repeat (3) @(posedge clk_500Hz);
        #1 rst = 1'b0;
        @(negedge clk_500Hz);
        check("rst_pin", userPin, 0);
        check("rst_vp", validPin, 0);
        check("rst_cnt", digit_count, 0);
        check("rst_active", entry_active, 0);
        check("rst_locked", locked, 0);
        @(posedge clk_500Hz);
        #1;

        // Full entry answered by success
        submit(16'h1234, 1);
        check("ok_active", entry_active, 0);
        check("ok_locked", locked, 0);

        // Debounce latency, invalid digit ignored
        digit_sw = 4'd5;
        btnC = 1'b1;
        repeat (DB) @(posedge clk_500Hz);
        @(negedge clk_500Hz);
        check("lat_pre", digit_count, 0);
        @(posedge clk_500Hz);
        @(negedge clk_500Hz);
        check("lat_acc", digit_count, 1);
        check("entry_on", entry_active, 1);
        @(posedge clk_500Hz);
        #1 btnC = 1'b0;
        repeat (DB + 2) @(posedge clk_500Hz);
        #1;
        press(4'hB);
        press(4'd6);
        check("two_cnt", digit_count, 2);
        check("two_pin", userPin, 16'h0056);

        // Enter and clear pressed together: clear wins
        press_clear(1'b1);
        check("both_cnt", digit_count, 0);
        check("both_pin", userPin, 0);
        check("both_active", entry_active, 0);

        // Events outside WAIT_RESULT are ignored
        press(4'd1);
        press(4'd2);
        press(4'd3);
        pulse_events(1'b1, 1'b0);
        pulse_events(1'b0, 1'b1);
        check("evt_ign_cnt", digit_count, 3);
        check("evt_ign_pin", userPin, 16'h0123);
        press_clear(1'b0);
        check("clr_cnt", digit_count, 0);

        // Inactivity timeout
        press(4'd7);
        press(4'd8);
        repeat (ET - 200) @(posedge clk_500Hz);
        @(negedge clk_500Hz);
        check("to_pre_active", entry_active, 1);
        check("to_pre_cnt", digit_count, 2);
        repeat (300) @(posedge clk_500Hz);
        @(negedge clk_500Hz);
        check("to_cnt", digit_count, 0);
        check("to_active", entry_active, 0);
        check("to_pin", userPin, 0);
        @(posedge clk_500Hz);
        #1;

`ifdef PIN_ENTRY_LOCKOUT_EN
        submit(16'h0001, 2);
        check("f1_locked", locked, 0);
        submit(16'h9999, 2);
        check("f2_locked", locked, 0);
        submit(16'h4321, 0);
        check("rto_locked", locked, 0);
        submit(16'h5678, 2);
        check("lock_on", locked, 1);
        press(4'd1);
        pulse_events(1'b0, 1'b1);
        check("lock_cnt", digit_count, 0);
        check("lock_active", entry_active, 0);
        check("lock_still", locked, 1);
        for (int i = 0; i < LC + 200; i++) begin
            @(negedge clk_500Hz);
            if (!locked) break;
        end
        check("unlock", locked, 0);
        @(posedge clk_500Hz);
        #1;
        // Success (winning over a simultaneous fail) resets the fail streak
        submit(16'h1111, 2);
        submit(16'h2222, 2);
        submit(16'h3333, 3);
        submit(16'h4444, 2);
        submit(16'h5555, 2);
        check("streak_locked", locked, 0);
`else
        submit(16'h0001, 2);
        submit(16'h9999, 2);
        submit(16'h4321, 0);
        submit(16'h5678, 2);
        check("nolock_locked", locked, 0);
        submit(16'h3333, 3);
        check("nolock_locked2", locked, 0);
`endif

        // Reset while in SUBMIT cancels the pulse
        press(4'd9);
        press(4'd8);
        press(4'd7);
        digit_sw = 4'd6;
        btnC = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_500Hz);
            if (digit_count == 3'd4) begin
                seen = 1'b1;
                break;
            end
        end
        check("sub_reached", {31'b0, seen}, 1);
        rst = 1'b1;
        btnC = 1'b0;
        @(posedge clk_500Hz);
        #1 rst = 1'b0;
        @(negedge clk_500Hz);
        check("srst_vp", validPin, 0);
        check("srst_cnt", digit_count, 0);
        check("srst_pin", userPin, 0);
        check("srst_active", entry_active, 0);
        check("srst_locked", locked, 0);
        repeat (12) @(posedge clk_500Hz);
        #1;
        check("srst_no_vp", vp_count, sb_pushed);

        check("sb_drain", sb_q.size(), 0);
`ifdef PIN_ENTRY_LOCKOUT_EN
        check("lock_len", lock_cycles, LC);
`else
        check("lock_len", lock_cycles, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
